mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port main memory (burst model, DELAY_CYCLES latency, BURST_LEN beats per transaction) between the L1 instruction cache (read-only line fills) and the L1 data cache (line fills and dirty-line writebacks).
- Sits inside the OTTER memory wrapper, between the cache controllers/line adapters and the main memory.
- Grants one burst at a time and round-robins between ports on contention.
- Counts beats, routes read data back to the owning port, and sequences write data beat by beat.

Parameters:
- BURST_LEN, 4, words per line transaction; power of two, ≥2.
- ADDR_W, 32, address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- I_REQ  in  1  I-cache line-fill request; held high until I_DONE.
- I_ADDR  in  ADDR_W  I-cache line address; low log2(BURST_LEN)+2 bits ignored.
- D_REQ  in  1  D-cache request; held high until D_DONE.
- D_WE  in  1  1 = writeback, 0 = fill; sampled at grant.
- D_ADDR  in  ADDR_W  D-cache line address; same alignment rule as I_ADDR.
- D_WDATA  in  32  writeback word selected by D_BEAT (combinational from requester).
- I_RDATA  out  32  fill beat data.
- I_RVALID  out  1  I_RDATA valid this cycle.
- I_DONE  out  1  one-cycle pulse: I transaction complete.
- D_RDATA  out  32  fill beat data.
- D_RVALID  out  1  D_RDATA valid this cycle.
- D_DONE  out  1  one-cycle pulse: D transaction complete.
- D_BEAT  out  log2(BURST_LEN)  current beat index.
- MEM_RE  out  1  memory read enable, held for the whole burst.
- MEM_WE  out  1  memory write enable, held for the whole burst.
- MEM_ADDR  out  ADDR_W  aligned line base address, held for the whole burst.
- MEM_DIN  out  32  write data to memory.
- MEM_DOUT  in  32  read data from memory.
- MEM_VALID  in  1  memory beat strobe.
- BUSY  out  1  high in any state except IDLE.

Behaviour:
- States: IDLE, I_XFER, D_XFER, DONE. One-bit last_grant register; one beat counter beat[log2(BURST_LEN)-1:0].
- Reset (RST high at a clock edge, including mid-burst):
  - state = IDLE, beat = 0, last_grant = I.
  - MEM_RE, MEM_WE, MEM_ADDR, *_DONE and BUSY are all 0 the next cycle.
  - An interrupted transaction is abandoned with no DONE pulse; the requester must re-request.
- IDLE arbitration:
  - Only I_REQ → I_XFER. Only D_REQ → D_XFER.
  - Both asserted → grant the port that is not last_grant. After reset D wins first.
  - On grant: latch the aligned address (addr & ~(BURST_LEN*4-1)), latch D_WE (the I port always reads), set last_grant, clear beat.
- Registered memory outputs:
  - MEM_RE/MEM_WE/MEM_ADDR rise in the first cycle of XFER, one cycle after the request is seen in IDLE.
  - They stay constant throughout XFER and are 0 in IDLE and DONE.
- XFER:
  - Each cycle with MEM_VALID=1: beat += 1.
  - Read transaction: owner's RVALID = MEM_VALID and RDATA = MEM_DOUT (combinational).
  - Write transaction: MEM_DIN = D_WDATA for the current D_BEAT; D_WDATA must be stable whenever D_BEAT is.
  - On the MEM_VALID that completes beat BURST_LEN-1 → DONE; beat wraps to 0.
- DONE (exactly one cycle): owner's *_DONE = 1, BUSY = 1, → IDLE. Arbitration resumes in IDLE, so a minimum of one idle cycle separates bursts. This gives memory turnaround.
- Non-owner outputs: the non-owning port's RVALID/DONE are always 0. *_RDATA may mirror MEM_DOUT when not valid.
- MEM_VALID in IDLE or DONE is ignored: no counter change, no RVALID.
- Requester behaviour mid-burst:
  - Deasserting REQ mid-burst does not abort; the burst completes and DONE still pulses.
  - Address and D_WE changes after grant are ignored.
- D_BEAT = beat in all states; it is 0 in IDLE.
- No timeout: an XFER state with no MEM_VALID waits indefinitely.

Test Plan:
- I_REQ=1, I_ADDR=0x0000_1234 → MEM_RE=1 and MEM_ADDR=0x0000_1230 next cycle. After 10 delay cycles, 4 MEM_VALID beats return 0xA0..0xA3 on I_RDATA with I_RVALID, then I_DONE pulses once. D_RVALID stays 0 throughout.
- D_REQ=1, D_WE=1, D_ADDR=0x40, requester drives D_WDATA=0x100+D_BEAT → MEM_WE=1 and MEM_DIN sequence 0x100, 0x101, 0x102, 0x103 aligned with MEM_VALID beats, then D_DONE.
- I_REQ and D_REQ rise together out of reset → D served first. I is granted in the IDLE cycle after D_DONE. On a repeated collision I wins, since last_grant is now D.
- D_REQ held for two back-to-back fills → exactly one IDLE cycle between the DONE of the first and MEM_RE of the second. D_BEAT restarts at 0.
- RST asserted after beat 2 of an I fill → next cycle MEM_RE=0, BUSY=0, D_BEAT=0, no I_DONE. A re-issued I_REQ performs a full 4-beat burst.
- MEM_VALID pulsed while IDLE, and I_REQ dropped mid-burst → no RVALID in IDLE. The burst still completes 4 beats and I_DONE pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Burst arbiter sharing one single-port main memory between the L1 I-cache (fills)
// and the L1 D-cache (fills and writebacks); round-robin on contention.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no burst in flight; arbitrate between I_REQ and D_REQ
// I_XFER | I-cache line fill in progress, counting MEM_VALID beats
// D_XFER | D-cache fill or writeback in progress, counting beats
// DONE   | one-cycle completion pulse to the owner; memory turnaround
module mem_port_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         I_REQ,
  input  logic [ADDR_W-1:0]            I_ADDR,
  input  logic                         D_REQ,
  input  logic                         D_WE,
  input  logic [ADDR_W-1:0]            D_ADDR,
  input  logic [31:0]                  D_WDATA,
  output logic [31:0]                  I_RDATA,
  output logic                         I_RVALID,
  output logic                         I_DONE,
  output logic [31:0]                  D_RDATA,
  output logic                         D_RVALID,
  output logic                         D_DONE,
  output logic [$clog2(BURST_LEN)-1:0] D_BEAT,
  output logic                         MEM_RE,
  output logic                         MEM_WE,
  output logic [ADDR_W-1:0]            MEM_ADDR,
  output logic [31:0]                  MEM_DIN,
  input  logic [31:0]                  MEM_DOUT,
  input  logic                         MEM_VALID,
  output logic                         BUSY
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BURST_LEN * 4 - 1));
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_grant_q, last_grant_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;

  logic grant_i;
  logic grant_d;
  logic in_xfer;

  // On a collision the port that did not win last time gets the bus.
  assign grant_i = I_REQ && (!D_REQ || (last_grant_q == GRANT_D));
  assign grant_d = D_REQ && (!I_REQ || (last_grant_q == GRANT_I));
  assign in_xfer = (state_q == I_XFER) || (state_q == D_XFER);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (grant_i) begin
          state_d      = I_XFER;
          last_grant_d = GRANT_I;
          mem_re_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = I_ADDR & ALIGN_MASK;
        end else if (grant_d) begin
          state_d      = D_XFER;
          last_grant_d = GRANT_D;
          mem_re_d     = !D_WE;
          mem_we_d     = D_WE;
          mem_addr_d   = D_ADDR & ALIGN_MASK;
        end
      end
      I_XFER, D_XFER: begin
        if (MEM_VALID) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d    = DONE;
            mem_re_d   = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d   = (state_d != IDLE);
    i_done_d = (state_d == DONE) && (last_grant_d == GRANT_I);
    d_done_d = (state_d == DONE) && (last_grant_d == GRANT_D);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      last_grant_q <= GRANT_I;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  // Read data is steered straight through; only the owner sees a valid strobe.
  assign I_RDATA  = MEM_DOUT;
  assign D_RDATA  = MEM_DOUT;
  assign I_RVALID = in_xfer && (state_q == I_XFER) && MEM_VALID;
  assign D_RVALID = in_xfer && (state_q == D_XFER) && mem_re_q && MEM_VALID;
  assign I_DONE   = i_done_q;
  assign D_DONE   = d_done_q;
  assign D_BEAT   = beat_q;
  assign MEM_RE   = mem_re_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DIN  = D_WDATA;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-scenario tasks plus a negedge
// scoreboard that pops expected read/write beats as the DUT produces them.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RST;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [31:0] I_RDATA;
  logic        I_RVALID;
  logic        I_DONE;
  logic [31:0] D_RDATA;
  logic        D_RVALID;
  logic        D_DONE;
  logic [1:0]  D_BEAT;
  logic        MEM_RE;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_DIN;
  logic [31:0] MEM_DOUT;
  logic        MEM_VALID;
  logic        BUSY;

  int vectors     = 0;
  int miscompares = 0;
  int i_done_cnt  = 0;
  int d_done_cnt  = 0;

  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  logic [31:0] w_q[$];
  logic [31:0] mon_exp;

  mem_port_arbiter #(.BURST_LEN(4), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .I_RDATA(I_RDATA), .I_RVALID(I_RVALID), .I_DONE(I_DONE),
    .D_RDATA(D_RDATA), .D_RVALID(D_RVALID), .D_DONE(D_DONE), .D_BEAT(D_BEAT),
    .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT), .MEM_VALID(MEM_VALID), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Writeback requester: word chosen by the beat index the arbiter presents.
  always_comb D_WDATA = 32'h100 + 32'(D_BEAT);

  always @(negedge CLK) begin
    if (I_RVALID === 1'b1) begin
      vectors++;
      if (i_q.size() == 0) begin
        miscompares++;
        $display("FAIL i_rvalid: got I_RDATA=%h with I_RVALID=1, required I_RVALID=0", I_RDATA);
      end else begin
        mon_exp = i_q.pop_front();
        if (I_RDATA !== mon_exp) begin
          miscompares++;
          $display("FAIL i_rdata: got %h, required %h", I_RDATA, mon_exp);
        end
      end
    end
    if (D_RVALID === 1'b1) begin
      vectors++;
      if (d_q.size() == 0) begin
        miscompares++;
        $display("FAIL d_rvalid: got D_RDATA=%h with D_RVALID=1, required D_RVALID=0", D_RDATA);
      end else begin
        mon_exp = d_q.pop_front();
        if (D_RDATA !== mon_exp) begin
          miscompares++;
          $display("FAIL d_rdata: got %h, required %h", D_RDATA, mon_exp);
        end
      end
    end
    if (MEM_VALID === 1'b1 && MEM_WE === 1'b1) begin
      vectors++;
      if (w_q.size() == 0) begin
        miscompares++;
        $display("FAIL mem_din: got write beat %h, required no write beat", MEM_DIN);
      end else begin
        mon_exp = w_q.pop_front();
        if (MEM_DIN !== mon_exp) begin
          miscompares++;
          $display("FAIL mem_din: got %h, required %h", MEM_DIN, mon_exp);
        end
      end
    end
    if (I_DONE === 1'b1) i_done_cnt++;
    if (D_DONE === 1'b1) d_done_cnt++;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_serve(input int delay, input logic [31:0] base, input int nbeats);
    for (int k = 0; k < delay; k++) tick();
    for (int k = 0; k < nbeats; k++) begin
      MEM_VALID = 1'b1;
      MEM_DOUT  = base + 32'(k);
      tick();
    end
    MEM_VALID = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    vectors++;
    if ({MEM_RE, MEM_WE, BUSY, I_DONE, D_DONE} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got RE/WE/BUSY/IDONE/DDONE=%b, required 00000",
               {MEM_RE, MEM_WE, BUSY, I_DONE, D_DONE});
    end
    vectors++;
    if (MEM_ADDR !== 32'h0 || D_BEAT !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_addr_beat: got MEM_ADDR=%h D_BEAT=%0d, required 0 and 0", MEM_ADDR, D_BEAT);
    end
  endtask

  task automatic test_i_fill;
    int done0;
    done0  = i_done_cnt;
    I_ADDR = 32'h0000_1234;
    I_REQ  = 1'b1;
    for (int k = 0; k < 4; k++) i_q.push_back(32'hA0 + 32'(k));
    tick();
    vectors++;
    if (MEM_RE !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 32'h0000_1230 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL i_fill_grant: got RE=%b WE=%b ADDR=%h BUSY=%b, required 1 0 00001230 1",
               MEM_RE, MEM_WE, MEM_ADDR, BUSY);
    end
    mem_serve(10, 32'hA0, 4);
    vectors++;
    if (I_DONE !== 1'b1 || D_DONE !== 1'b0 || MEM_RE !== 1'b0 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL i_fill_done: got IDONE=%b DDONE=%b RE=%b BUSY=%b, required 1 0 0 1",
               I_DONE, D_DONE, MEM_RE, BUSY);
    end
    I_REQ = 1'b0;
    tick();
    vectors++;
    if (I_DONE !== 1'b0 || BUSY !== 1'b0 || i_q.size() != 0 || i_done_cnt != done0 + 1) begin
      miscompares++;
      $display("FAIL i_fill_end: got IDONE=%b BUSY=%b left=%0d pulses=%0d, required 0 0 0 1",
               I_DONE, BUSY, i_q.size(), i_done_cnt - done0);
    end
  endtask

  task automatic test_d_writeback;
    int done0;
    done0  = d_done_cnt;
    D_ADDR = 32'h40;
    D_WE   = 1'b1;
    D_REQ  = 1'b1;
    for (int k = 0; k < 4; k++) w_q.push_back(32'h100 + 32'(k));
    tick();
    vectors++;
    if (MEM_WE !== 1'b1 || MEM_RE !== 1'b0 || MEM_ADDR !== 32'h40) begin
      miscompares++;
      $display("FAIL d_wb_grant: got WE=%b RE=%b ADDR=%h, required 1 0 00000040", MEM_WE, MEM_RE, MEM_ADDR);
    end
    D_WE   = 1'b0;
    D_ADDR = 32'h999;
    mem_serve(3, 32'hDEAD_0000, 2);
    vectors++;
    if (MEM_WE !== 1'b1 || MEM_ADDR !== 32'h40 || D_BEAT !== 2'd2) begin
      miscompares++;
      $display("FAIL d_wb_hold: got WE=%b ADDR=%h BEAT=%0d, required 1 00000040 2", MEM_WE, MEM_ADDR, D_BEAT);
    end
    mem_serve(1, 32'hDEAD_0002, 2);
    D_REQ = 1'b0;
    vectors++;
    if (D_DONE !== 1'b1 || I_DONE !== 1'b0 || MEM_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL d_wb_done: got DDONE=%b IDONE=%b WE=%b, required 1 0 0", D_DONE, I_DONE, MEM_WE);
    end
    tick();
    vectors++;
    if (w_q.size() != 0 || d_done_cnt != done0 + 1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL d_wb_end: got left=%0d pulses=%0d BUSY=%b, required 0 1 0",
               w_q.size(), d_done_cnt - done0, BUSY);
    end
  endtask

  task automatic test_contention;
    RST = 1'b1;
    tick();
    RST    = 1'b0;
    I_ADDR = 32'h2000;
    D_ADDR = 32'h3008;
    D_WE   = 1'b0;
    I_REQ  = 1'b1;
    D_REQ  = 1'b1;
    for (int k = 0; k < 4; k++) d_q.push_back(32'hB0 + 32'(k));
    tick();
    vectors++;
    if (MEM_RE !== 1'b1 || MEM_ADDR !== 32'h3000) begin
      miscompares++;
      $display("FAIL first_collision: got RE=%b ADDR=%h, required 1 00003000 (D first)", MEM_RE, MEM_ADDR);
    end
    mem_serve(2, 32'hB0, 4);
    vectors++;
    if (D_DONE !== 1'b1 || I_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_d_done: got DDONE=%b IDONE=%b, required 1 0", D_DONE, I_DONE);
    end
    for (int k = 0; k < 4; k++) i_q.push_back(32'hC0 + 32'(k));
    tick();
    vectors++;
    if (BUSY !== 1'b0 || MEM_RE !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_idle: got BUSY=%b RE=%b, required 0 0", BUSY, MEM_RE);
    end
    tick();
    vectors++;
    if (MEM_RE !== 1'b1 || MEM_ADDR !== 32'h2000) begin
      miscompares++;
      $display("FAIL second_collision: got RE=%b ADDR=%h, required 1 00002000 (I wins)", MEM_RE, MEM_ADDR);
    end
    mem_serve(1, 32'hC0, 4);
    I_REQ = 1'b0;
    vectors++;
    if (I_DONE !== 1'b1 || D_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_i_done: got IDONE=%b DDONE=%b, required 1 0", I_DONE, D_DONE);
    end
    for (int k = 0; k < 4; k++) d_q.push_back(32'hD0 + 32'(k));
    tick();
    tick();
    vectors++;
    if (MEM_RE !== 1'b1 || MEM_ADDR !== 32'h3000) begin
      miscompares++;
      $display("FAIL d_after_i: got RE=%b ADDR=%h, required 1 00003000", MEM_RE, MEM_ADDR);
    end
    mem_serve(0, 32'hD0, 4);
    D_REQ = 1'b0;
    tick();
    vectors++;
    if (d_q.size() != 0 || i_q.size() != 0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_end: got dleft=%0d ileft=%0d BUSY=%b, required 0 0 0", d_q.size(), i_q.size(), BUSY);
    end
  endtask

  task automatic test_back_to_back;
    int done0;
    done0  = d_done_cnt;
    D_ADDR = 32'h8C;
    D_WE   = 1'b0;
    D_REQ  = 1'b1;
    for (int k = 0; k < 4; k++) d_q.push_back(32'h10 + 32'(k));
    tick();
    mem_serve(2, 32'h10, 4);
    vectors++;
    if (D_DONE !== 1'b1 || MEM_RE !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done: got DDONE=%b RE=%b, required 1 0", D_DONE, MEM_RE);
    end
    for (int k = 0; k < 4; k++) d_q.push_back(32'h20 + 32'(k));
    tick();
    vectors++;
    if (MEM_RE !== 1'b0 || BUSY !== 1'b0 || D_BEAT !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_gap: got RE=%b BUSY=%b BEAT=%0d, required 0 0 0", MEM_RE, BUSY, D_BEAT);
    end
    tick();
    vectors++;
    if (MEM_RE !== 1'b1 || MEM_ADDR !== 32'h80 || D_BEAT !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_regrant: got RE=%b ADDR=%h BEAT=%0d, required 1 00000080 0", MEM_RE, MEM_ADDR, D_BEAT);
    end
    mem_serve(2, 32'h20, 4);
    D_REQ = 1'b0;
    tick();
    vectors++;
    if (d_q.size() != 0 || d_done_cnt != done0 + 2) begin
      miscompares++;
      $display("FAIL b2b_end: got left=%0d pulses=%0d, required 0 2", d_q.size(), d_done_cnt - done0);
    end
  endtask

  task automatic test_reset_mid_burst;
    int done0;
    done0  = i_done_cnt;
    I_ADDR = 32'h500;
    I_REQ  = 1'b1;
    for (int k = 0; k < 3; k++) i_q.push_back(32'hE0 + 32'(k));
    tick();
    mem_serve(2, 32'hE0, 3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++;
    if (MEM_RE !== 1'b0 || BUSY !== 1'b0 || D_BEAT !== 2'd0 || I_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got RE=%b BUSY=%b BEAT=%0d IDONE=%b, required 0 0 0 0",
               MEM_RE, BUSY, D_BEAT, I_DONE);
    end
    for (int k = 0; k < 4; k++) i_q.push_back(32'hF0 + 32'(k));
    tick();
    vectors++;
    if (MEM_RE !== 1'b1 || MEM_ADDR !== 32'h500) begin
      miscompares++;
      $display("FAIL reissue_grant: got RE=%b ADDR=%h, required 1 00000500", MEM_RE, MEM_ADDR);
    end
    mem_serve(1, 32'hF0, 4);
    I_REQ = 1'b0;
    tick();
    vectors++;
    if (i_q.size() != 0 || i_done_cnt != done0 + 1) begin
      miscompares++;
      $display("FAIL reissue_end: got left=%0d pulses=%0d, required 0 1", i_q.size(), i_done_cnt - done0);
    end
  endtask

  task automatic test_idle_valid_and_drop;
    int done0;
    done0     = i_done_cnt;
    MEM_VALID = 1'b1;
    MEM_DOUT  = 32'h55;
    tick();
    tick();
    MEM_VALID = 1'b0;
    vectors++;
    if (D_BEAT !== 2'd0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_valid: got BEAT=%0d BUSY=%b, required 0 0", D_BEAT, BUSY);
    end
    I_ADDR = 32'h61F;
    I_REQ  = 1'b1;
    for (int k = 0; k < 4; k++) i_q.push_back(32'h70 + 32'(k));
    tick();
    I_REQ = 1'b0;
    vectors++;
    if (MEM_RE !== 1'b1 || MEM_ADDR !== 32'h610) begin
      miscompares++;
      $display("FAIL drop_grant: got RE=%b ADDR=%h, required 1 00000610", MEM_RE, MEM_ADDR);
    end
    mem_serve(4, 32'h70, 4);
    MEM_VALID = 1'b1;
    MEM_DOUT  = 32'h66;
    vectors++;
    if (I_DONE !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_done: got IDONE=%b, required 1", I_DONE);
    end
    tick();
    MEM_VALID = 1'b0;
    tick();
    vectors++;
    if (i_q.size() != 0 || i_done_cnt != done0 + 1 || D_BEAT !== 2'd0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_end: got left=%0d pulses=%0d BEAT=%0d BUSY=%b, required 0 1 0 0",
               i_q.size(), i_done_cnt - done0, D_BEAT, BUSY);
    end
  endtask

  initial begin
    RST       = 1'b1;
    I_REQ     = 1'b0;
    I_ADDR    = '0;
    D_REQ     = 1'b0;
    D_WE      = 1'b0;
    D_ADDR    = '0;
    MEM_DOUT  = '0;
    MEM_VALID = 1'b0;
    test_reset();
    test_i_fill();
    test_d_writeback();
    test_contention();
    test_back_to_back();
    test_reset_mid_burst();
    test_idle_valid_and_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run by 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
